ebus_pi_requester: RTL and testbench

// - Device-side EBUS interrupt/IO interface; sits directly upstream of the PI board, driving one of ebus_pi01..07.
// - Holds the PIA/enable/done-flag CONO-CONI state and the interrupt vector.
// - Answers PI-board and APR EBUS cycles (demand/xfer handshake) addressed to its controller number.
// - Supplies the vector on PI_ADR_IN.

---
 rtl/ebus_pi_requester_pkg.sv | 63 ++++++
 rtl/ebus_pi_requester_if.sv | 24 ++
 rtl/ebus_pi_requester_slave_hs.sv | 99 +++++++++
 rtl/ebus_pi_requester.sv | 147 ++++++++++++++
 tb/tb_ebus_pi_requester.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ebus_pi_requester_pkg.sv
// EBUS device-side shared definitions: function codes, FSM states,
// CONO/CONI field positions (PDP-10 bit numbering, bit 0 = MSB) and helpers.
package ebus_pkg;

  localparam int EBUS_W = 36;

  typedef enum logic [2:0] {
    F_CONO      = 3'd0,
    F_CONI      = 3'd1,
    F_DATAO     = 3'd2,
    F_DATAI     = 3'd3,
    F_PI_SERVED = 3'd4,
    F_PI_ADR_IN = 3'd7
  } ebus_func_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    REL   = 2'd3
  } ebus_state_t;

  // CONO write fields
  localparam int CONO_CLR_INSVC = 30;
  localparam int CONO_CLR_DONE  = 31;
  localparam int CONO_ENA       = 32;
  localparam int CONO_PIA_MSB   = 33;
  localparam int CONO_PIA_LSB   = 35;

  // CONI read fields
  localparam int CONI_INSVC   = 30;
  localparam int CONI_DONE    = 31;
  localparam int CONI_ENA     = 32;
  localparam int CONI_PIA_MSB = 33;
  localparam int CONI_PIA_LSB = 35;

  // Vector field for DATAO/DATAI/PI_ADR_IN
  localparam int VEC_MSB = 18;
  localparam int VEC_LSB = 35;

  // Codes 5 and 6 are reserved and never answered.
  function automatic logic is_known_func(input logic [2:0] f);
    return (f != 3'd5) && (f != 3'd6);
  endfunction

  // Functions for which the device drives the data lines.
  function automatic logic is_read_func(input logic [2:0] f);
    return (f == F_CONI) || (f == F_DATAI) || (f == F_PI_ADR_IN);
  endfunction

  // One-hot PI level request; level 0 means no request.
  function automatic logic [1:7] pi_onehot(input logic [2:0] lvl);
    logic [1:7] v;
    v = 7'b0000000;
    if (lvl != 3'd0) begin
      v[lvl] = 1'b1;
    end else begin
      v = 7'b0000000;
    end
    return v;
  endfunction

endpackage

// File: rtl/ebus_pi_requester_if.sv
// EBUS cycle signals between the PI board / APR (master) and a device (slave).
interface ebus_pi_requester_if;
  import ebus_pkg::*;

  logic [6:0]        ebus_cs_e_h;
  logic [2:0]        ebus_f_e_h;
  logic              ebus_demand_e_h;
  logic [0:EBUS_W-1] ebus_d_in_e_h;
  logic [0:EBUS_W-1] ebus_d_out_e_h;
  logic              ebus_d_oe_h;
  logic              ebus_xfer_e_h;
  logic [1:7]        ebus_pi_e_h;

  modport master (
    output ebus_cs_e_h, ebus_f_e_h, ebus_demand_e_h, ebus_d_in_e_h,
    input  ebus_d_out_e_h, ebus_d_oe_h, ebus_xfer_e_h, ebus_pi_e_h
  );

  modport slave (
    input  ebus_cs_e_h, ebus_f_e_h, ebus_demand_e_h, ebus_d_in_e_h,
    output ebus_d_out_e_h, ebus_d_oe_h, ebus_xfer_e_h, ebus_pi_e_h
  );

endinterface

// File: rtl/ebus_pi_requester_slave_hs.sv
// Generic EBUS slave demand/xfer handshake: IDLE -> SETUP (SETUP_CYC cycles)
// -> XFER (while demand) -> REL -> IDLE. Demand loss in SETUP aborts to REL.
// start/commit/drop are single-cycle strobes for the owning device.
module ebus_slave_hs
  import ebus_pkg::*;
#(
  parameter int SETUP_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel,     // cycle addressed to this device (only honoured in IDLE)
  input  logic demand,
  input  logic rd,      // selected function drives data
  output logic xfer,
  output logic oe,
  output logic start,   // IDLE -> SETUP edge: latch function and write data
  output logic commit,  // SETUP -> XFER edge: apply write side effects
  output logic drop     // demand lost in SETUP/XFER: release the bus
);

  localparam logic [2:0] LAST_CNT = 3'(SETUP_CYC - 1);

  ebus_state_t state_r, state_nxt_s;
  logic [2:0]  cnt_r, cnt_nxt_s;
  logic        xfer_r, xfer_nxt_s;
  logic        oe_r, oe_nxt_s;

  // State, setup counter and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      xfer_r  <= 1'b0;
      oe_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      xfer_r  <= xfer_nxt_s;
      oe_r    <= oe_nxt_s;
    end
  end

  // Next-state, next-output and strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    xfer_nxt_s  = 1'b0;
    oe_nxt_s    = oe_r;
    start       = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel) begin
          state_nxt_s = SETUP;
          cnt_nxt_s   = 3'd0;
          oe_nxt_s    = rd;
          start       = 1'b1;
        end else begin
          oe_nxt_s = 1'b0;
        end
      end
      SETUP: begin
        if (!demand) begin
          state_nxt_s = REL;
          oe_nxt_s    = 1'b0;
          drop        = 1'b1;
        end else if (cnt_r == LAST_CNT) begin
          state_nxt_s = XFER;
          xfer_nxt_s  = 1'b1;
          commit      = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      XFER: begin
        if (!demand) begin
          state_nxt_s = REL;
          oe_nxt_s    = 1'b0;
          drop        = 1'b1;
        end else begin
          xfer_nxt_s = 1'b1;
        end
      end
      REL: begin
        state_nxt_s = IDLE;
        oe_nxt_s    = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        oe_nxt_s    = 1'b0;
      end
    endcase
  end

  assign xfer = xfer_r;
  assign oe   = oe_r;

endmodule

// File: rtl/ebus_pi_requester.sv
// EBUS PI requester: CONO/CONI control state, interrupt vector, PI level
// request and the read-data mux, on top of the generic slave handshake.
module ebus_pi_requester
  import ebus_pkg::*;
#(
  parameter logic [6:0]  CTL_NUM   = 7'o10,
  parameter logic [17:0] VEC_RESET = 18'o0,
  parameter int          SETUP_CYC = 2
) (
  input  logic                      clk_ebus_h,
  input  logic                      mr_reset_l,
  ebus_pi_requester_if.slave        ebus,
  input  logic                      dev_done_h,
  output logic                      dev_flag_h
);

  logic [2:0]            pia_r;
  logic                  ena_r;
  logic                  done_r;
  logic                  insvc_r;
  logic [17:0]           vector_r;
  ebus_func_t            func_r;
  logic [VEC_MSB:VEC_LSB] wd_r;
  logic [1:7]            pi_r;
  logic [0:EBUS_W-1]     d_out_r;
  logic [0:EBUS_W-1]     rd_data_s;

  logic sel_s, rd_s, req_active_s;
  logic xfer_s, oe_s, start_s, commit_s, drop_s;
  logic d_in_unused_s;

  // Only the low half of the data word carries write payload.
  assign d_in_unused_s = ^ebus.ebus_d_in_e_h[0:VEC_MSB-1];

  assign req_active_s = |pi_r;
  assign rd_s         = is_read_func(ebus.ebus_f_e_h);
  // PI_ADR_IN is only answered while this device is requesting.
  assign sel_s = ebus.ebus_demand_e_h && (ebus.ebus_cs_e_h == CTL_NUM) &&
                 is_known_func(ebus.ebus_f_e_h) &&
                 ((ebus.ebus_f_e_h != F_PI_ADR_IN) || req_active_s);

  ebus_slave_hs #(.SETUP_CYC(SETUP_CYC)) u_hs (
    .clk    (clk_ebus_h),
    .rst_n  (mr_reset_l),
    .sel    (sel_s),
    .demand (ebus.ebus_demand_e_h),
    .rd     (rd_s),
    .xfer   (xfer_s),
    .oe     (oe_s),
    .start  (start_s),
    .commit (commit_s),
    .drop   (drop_s)
  );

  // Read data for the function presented on the bus.
  always_comb begin
    rd_data_s = '0;
    case (ebus.ebus_f_e_h)
      F_CONI: begin
        rd_data_s[CONI_INSVC]                = insvc_r;
        rd_data_s[CONI_DONE]                 = done_r;
        rd_data_s[CONI_ENA]                  = ena_r;
        rd_data_s[CONI_PIA_MSB:CONI_PIA_LSB] = pia_r;
      end
      F_DATAI, F_PI_ADR_IN: begin
        rd_data_s[VEC_MSB:VEC_LSB] = vector_r;
      end
      default: begin
        rd_data_s = '0;
      end
    endcase
  end

  // Capture function code and write payload as the cycle enters SETUP.
  always_ff @(posedge clk_ebus_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      func_r <= F_CONO;
      wd_r   <= '0;
    end else if (start_s) begin
      func_r <= ebus_func_t'(ebus.ebus_f_e_h);
      wd_r   <= ebus.ebus_d_in_e_h[VEC_MSB:VEC_LSB];
    end
  end

  // Control/vector registers; writes take effect only once XFER is reached.
  always_ff @(posedge clk_ebus_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      pia_r    <= 3'd0;
      ena_r    <= 1'b0;
      insvc_r  <= 1'b0;
      vector_r <= VEC_RESET;
    end else if (commit_s) begin
      case (func_r)
        F_CONO: begin
          ena_r <= wd_r[CONO_ENA];
          pia_r <= wd_r[CONO_PIA_MSB:CONO_PIA_LSB];
          if (wd_r[CONO_CLR_INSVC]) begin
            insvc_r <= 1'b0;
          end
        end
        F_DATAO:     vector_r <= wd_r;
        F_PI_SERVED: insvc_r  <= 1'b1;
        default:     vector_r <= vector_r;
      endcase
    end
  end

  // DONE flag: a device event beats a simultaneous CONO clear.
  always_ff @(posedge clk_ebus_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      done_r <= 1'b0;
    end else if (dev_done_h) begin
      done_r <= 1'b1;
    end else if (commit_s && (func_r == F_CONO) && wd_r[CONO_CLR_DONE]) begin
      done_r <= 1'b0;
    end
  end

  // Registered PI level request.
  always_ff @(posedge clk_ebus_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      pi_r <= 7'b0000000;
    end else if (done_r && ena_r && !insvc_r) begin
      pi_r <= pi_onehot(pia_r);
    end else begin
      pi_r <= 7'b0000000;
    end
  end

  // Read data is loaded when the cycle starts and cleared when it is released.
  always_ff @(posedge clk_ebus_h or negedge mr_reset_l) begin
    if (!mr_reset_l) begin
      d_out_r <= '0;
    end else if (start_s) begin
      d_out_r <= rd_data_s;
    end else if (drop_s) begin
      d_out_r <= '0;
    end
  end

  assign ebus.ebus_d_out_e_h = d_out_r;
  assign ebus.ebus_d_oe_h    = oe_s;
  assign ebus.ebus_xfer_e_h  = xfer_s;
  assign ebus.ebus_pi_e_h    = pi_r;
  assign dev_flag_h          = done_r;

endmodule

// File: tb/tb_ebus_pi_requester.sv
// Bench for ebus_pi_requester: directed scenarios plus random EBUS cycles,
// scored against an abstract model of the device registers.
module tb_ebus_pi_requester;

  localparam logic [6:0] CTL = 7'o10;
  localparam int         SC  = 2;

  logic clk      = 1'b0;
  logic rst_l    = 1'b1;
  logic dev_done = 1'b0;
  logic dev_flag;

  ebus_pi_requester_if bus();

  ebus_pi_requester #(.CTL_NUM(CTL), .VEC_RESET(18'o0), .SETUP_CYC(SC)) dut (
    .clk_ebus_h (clk),
    .mr_reset_l (rst_l),
    .ebus       (bus),
    .dev_done_h (dev_done),
    .dev_flag_h (dev_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Abstract device state
  logic [2:0]  m_pia;
  bit          m_ena, m_done, m_insvc;
  logic [17:0] m_vec;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [35:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_pass = 0, n_total = 0;
  int xfer_seen = 0, xfer_exp = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [6:0] exp_pi();
    if (m_done && m_ena && !m_insvc && m_pia != 3'd0) return 7'b1000000 >> (m_pia - 3'd1);
    return 7'b0000000;
  endfunction

  // Numeric word: PDP bit k is numeric bit 35-k.
  function automatic logic [35:0] model_read(input logic [2:0] f);
    if (f == 3'd1) return {30'd0, m_insvc, m_done, m_ena, m_pia};
    if (f == 3'd3 || f == 3'd7) return {18'd0, m_vec};
    return 36'd0;
  endfunction

  function automatic logic [35:0] mk_cono(input bit clr_insvc, input bit clr_done,
                                          input bit ena, input logic [2:0] pia);
    return {30'd0, clr_insvc, clr_done, ena, pia};
  endfunction

  function automatic void model_reset();
    m_pia = 3'd0; m_ena = 0; m_done = 0; m_insvc = 0; m_vec = 18'o0;
  endfunction

  // Monitor: every xfer rising edge is matched against the oldest expectation.
  initial begin : monitor
    logic xfer_d, oe_d;
    int   oe_rise;
    exp_t e;
    xfer_d = 1'b0; oe_d = 1'b0; oe_rise = -1;
    forever begin
      @(posedge clk); #1;
      if (bus.ebus_d_oe_h && !oe_d) oe_rise = cyc;
      if (bus.ebus_xfer_e_h && !xfer_d) begin
        xfer_seen++;
        chk("xfer_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("xfer_cycle", 64'(cyc), 64'(e.cyc));
          chk("oe_at_xfer", 64'(bus.ebus_d_oe_h), 64'(e.rd));
          if (e.rd) begin
            chk("read_data", 64'(bus.ebus_d_out_e_h), 64'(e.data));
            chk("oe_cycle", 64'(oe_rise), 64'(e.cyc - SC));
          end
        end
      end
      xfer_d = bus.ebus_xfer_e_h;
      oe_d   = bus.ebus_d_oe_h;
    end
  end

  task automatic post_checks(input string tag);
    chk({tag, "_xfer_count"}, 64'(xfer_seen), 64'(xfer_exp));
    chk({tag, "_pi"}, 64'(bus.ebus_pi_e_h), 64'(exp_pi()));
    chk({tag, "_flag"}, 64'(dev_flag), 64'(m_done));
  endtask

  // One EBUS cycle. abort_at>=0: drop demand that many negedges after raising it.
  // done_at>0: pulse dev_done at that negedge (2 lines up with the commit edge).
  task automatic bus_cycle(input logic [6:0] cs, input logic [2:0] f, input logic [35:0] d,
                           input int abort_at, input int done_at);
    bit sel, rd;
    int t0, hold;
    logic [35:0] rdat;
    sel  = (cs == CTL) && !(f inside {3'd5, 3'd6}) && (f != 3'd7 || exp_pi() != 7'd0);
    rd   = f inside {3'd1, 3'd3, 3'd7};
    rdat = model_read(f);
    @(negedge clk);
    bus.ebus_cs_e_h     = cs;
    bus.ebus_f_e_h      = f;
    bus.ebus_d_in_e_h   = d;
    bus.ebus_demand_e_h = 1'b1;
    t0 = cyc;
    if (sel && abort_at < 0) begin
      sb_q.push_back('{t0 + 1 + SC, rd, rdat});
      xfer_exp++;
    end
    hold = (abort_at >= 0) ? abort_at : 1 + SC + int'($urandom_range(0, 3));
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      dev_done = (k == done_at);
    end
    bus.ebus_demand_e_h = 1'b0;
    @(negedge clk);
    dev_done = 1'b0;
    @(negedge clk);
    if (sel && abort_at < 0) begin
      case (f)
        3'd0: begin
          if (d[5]) m_insvc = 0;
          if (d[4]) m_done = 0;
          m_ena = d[3];
          m_pia = d[2:0];
        end
        3'd2:    m_vec = d[17:0];
        3'd4:    m_insvc = 1;
        default: ;
      endcase
    end
    if (done_at > 0) m_done = 1;
    @(negedge clk);
    post_checks("cycle");
  endtask

  // Device event: flag follows one cycle later, request one cycle after that.
  task automatic pulse_done();
    logic [6:0] old_pi;
    @(negedge clk);
    old_pi   = exp_pi();
    dev_done = 1'b1;
    m_done   = 1;
    @(negedge clk);
    dev_done = 1'b0;
    chk("done_flag_lat", 64'(dev_flag), 64'd1);
    chk("done_pi_hold", 64'(bus.ebus_pi_e_h), 64'(old_pi));
    @(negedge clk);
    chk("done_pi_lat", 64'(bus.ebus_pi_e_h), 64'(exp_pi()));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.ebus_cs_e_h     = 7'd0;
    bus.ebus_f_e_h      = 3'd0;
    bus.ebus_d_in_e_h   = '0;
    bus.ebus_demand_e_h = 1'b0;
    model_reset();

    #2 rst_l = 1'b0;
    #1;
    chk("rst_xfer", 64'(bus.ebus_xfer_e_h), 64'd0);
    chk("rst_oe", 64'(bus.ebus_d_oe_h), 64'd0);
    chk("rst_dout", 64'(bus.ebus_d_out_e_h), 64'd0);
    chk("rst_pi", 64'(bus.ebus_pi_e_h), 64'd0);
    chk("rst_flag", 64'(dev_flag), 64'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;

    // Reset register contents
    bus_cycle(CTL, 3'd1, 36'd0, -1, -1);
    bus_cycle(CTL, 3'd3, 36'd0, -1, -1);

    // Enable level 5, then a device event raises the request
    bus_cycle(CTL, 3'd0, mk_cono(0, 0, 1, 3'd5), -1, -1);
    pulse_done();
    chk("level5_request", 64'(bus.ebus_pi_e_h), 64'h04);
    chk("level5_flag", 64'(dev_flag), 64'd1);

    // Vector load and PI address read
    bus_cycle(CTL, 3'd2, {18'o777777, 18'o123456}, -1, -1);
    bus_cycle(CTL, 3'd7, 36'd0, -1, -1);

    // Served: request drops, insvc visible, PI_ADR_IN no longer answered
    bus_cycle(CTL, 3'd4, 36'd0, -1, -1);
    chk("served_pi", 64'(bus.ebus_pi_e_h), 64'd0);
    bus_cycle(CTL, 3'd1, 36'd0, -1, -1);
    bus_cycle(CTL, 3'd7, 36'd0, -1, -1);

    // Clear insvc: request returns
    bus_cycle(CTL, 3'd0, mk_cono(1, 0, 1, 3'd5), -1, -1);
    chk("insvc_clr_pi", 64'(bus.ebus_pi_e_h), 64'h04);

    // Not addressed / reserved functions
    bus_cycle(CTL + 7'd1, 3'd0, mk_cono(0, 1, 0, 3'd2), -1, -1);
    bus_cycle(CTL, 3'd5, mk_cono(0, 1, 0, 3'd2), -1, -1);
    bus_cycle(CTL, 3'd6, mk_cono(0, 1, 0, 3'd2), -1, -1);

    // Aborted CONO leaves pia/ena untouched
    bus_cycle(CTL, 3'd0, mk_cono(0, 1, 1, 3'd3), 1, -1);
    bus_cycle(CTL, 3'd1, 36'd0, -1, -1);

    // Device event coincident with CONO clear-done: done stays set
    bus_cycle(CTL, 3'd0, mk_cono(0, 1, 1, 3'd5), -1, 2);
    chk("set_wins_flag", 64'(dev_flag), 64'd1);

    // Asynchronous reset in the middle of a PI_ADR_IN transfer
    chk("pre_reset_pi", 64'(bus.ebus_pi_e_h), 64'h04);
    @(negedge clk);
    bus.ebus_cs_e_h     = CTL;
    bus.ebus_f_e_h      = 3'd7;
    bus.ebus_demand_e_h = 1'b1;
    sb_q.push_back('{cyc + 1 + SC, 1'b1, {18'd0, m_vec}});
    xfer_exp++;
    for (int k = 0; k < 10 && !bus.ebus_xfer_e_h; k++) @(negedge clk);
    chk("xfer_before_reset", 64'(bus.ebus_xfer_e_h), 64'd1);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_xfer", 64'(bus.ebus_xfer_e_h), 64'd0);
    chk("arst_oe", 64'(bus.ebus_d_oe_h), 64'd0);
    chk("arst_pi", 64'(bus.ebus_pi_e_h), 64'd0);
    chk("arst_dout", 64'(bus.ebus_d_out_e_h), 64'd0);
    bus.ebus_demand_e_h = 1'b0;
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    post_checks("after_reset");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [6:0]  cs;
      logic [35:0] d;
      int          ab;
      f  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : CTL;
      d  = {4'($urandom), 32'($urandom)};
      ab = ($urandom_range(0, 4) == 0) ? 1 : -1;
      bus_cycle(cs, f, d, ab, -1);
      if ($urandom_range(0, 2) == 0) pulse_done();
    end

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
